fsk_demodulate: RTL

Receive-side FSK demodulator. It recovers 14-bit Hamming codewords from the single-wire `fsk` line produced by the FSK modulator. The block counts rising edges of `fsk` inside fixed 16-cycle bit windows, slices each window to a bit, and assembles the bits LSB-first into a codeword. The codeword goes to the downstream Hamming decoder. The block shares `FSK_clk` and reset with the modulator, so bit and word framing are implicit; there is no sync preamble.

---
 rtl/fsk_pkg.sv | 30 +++
 rtl/fsk_bit_slicer.sv | 68 ++++++
 rtl/fsk_demodulate.sv | 81 ++++++++
 3 files changed

// File: rtl/fsk_pkg.sv
// Shared FSK constants and types, used by both the modulator and the demodulator.
// Any change here must be mirrored on both ends of the link.
package fsk_pkg;

   localparam int BIT_CYCLES = 16;
   localparam int WORD_BITS  = 14;
   localparam int THRESHOLD  = 6;
   localparam int CNT_ONE    = 8;
   localparam int CNT_ZERO   = 4;

   localparam int PH_W  = $clog2(BIT_CYCLES);
   localparam int CNT_W = 5;
   localparam int IDX_W = $clog2(WORD_BITS);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // One bit decision, valid in the cycle where strobe is high.
   typedef struct packed {
      logic strobe;
      logic bit_val;
      logic err;
   } slice_t;

   // Flags a window whose count is neither the nominal one nor the nominal zero.
   function automatic logic window_err(input logic [CNT_W-1:0] total);
      return (total != CNT_ZERO[CNT_W-1:0]) && (total != CNT_ONE[CNT_W-1:0]);
   endfunction

endpackage

// File: rtl/fsk_bit_slicer.sv
// Counts rising edges of fsk over fixed bit windows.
// Emits a combinational decision strobe plus the registered bit_out and bit_valid.
module fsk_bit_slicer
   import fsk_pkg::*;
(
   input  logic   FSK_clk,
   input  logic   reset_n,
   input  logic   fsk,
   output slice_t slice_o,
   output logic   bit_out_o,
   output logic   bit_valid_o
);

   localparam logic [PH_W-1:0] PH_MAX = PH_W'(BIT_CYCLES - 1);

   logic             fsk_d_q;
   logic [PH_W-1:0]  ph_q, ph_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [0:0]       state_q, state_d;
   logic             bit_q, bit_d;
   logic             valid_q, valid_d;

   logic             rise;
   logic [CNT_W-1:0] total;
   logic             decide;
   logic             dec_bit;
   logic             dec_err;

   always_comb begin
      // NOTE: every signal gets a value on every path, so no latch can be inferred.
      rise    = fsk & ~fsk_d_q;
      total   = cnt_q + {{(CNT_W-1){1'b0}}, rise};
      decide  = (state_q == ST_RUN) && (ph_q == '0);
      dec_bit = (total >= THRESHOLD[CNT_W-1:0]);
      dec_err = window_err(total);

      ph_d    = (ph_q == PH_MAX) ? '0 : ph_q + 1'b1;
      // IDLE lasts exactly one cycle after reset; RUN is then held until reset.
      state_d = ST_RUN;
      cnt_d   = decide ? '0 : total;
      valid_d = decide;
      bit_d   = decide ? dec_bit : bit_q;
   end

   always_ff @(posedge FSK_clk or negedge reset_n) begin
      if (!reset_n) begin
         fsk_d_q <= 1'b0;
         ph_q    <= '0;
         cnt_q   <= '0;
         state_q <= ST_IDLE;
         bit_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         fsk_d_q <= fsk;
         ph_q    <= ph_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         bit_q   <= bit_d;
         valid_q <= valid_d;
      end
   end

   assign slice_o     = '{strobe: decide, bit_val: dec_bit, err: dec_err};
   assign bit_out_o   = bit_q;
   assign bit_valid_o = valid_q;

endmodule

// File: rtl/fsk_demodulate.sv
// FSK demodulator top: the bit slicer feeds an LSB-first word assembler.
// Completed Hamming codewords are held on Hamcode_out together with a symbol-error flag.
module fsk_demodulate
   import fsk_pkg::*;
(
   input  logic                 FSK_clk,
   input  logic                 reset_n,
   input  logic                 fsk,
   output logic                 bit_out,
   output logic                 bit_valid,
   output logic [WORD_BITS-1:0] Hamcode_out,
   output logic                 word_valid,
   output logic                 sym_err
);

   localparam logic [IDX_W-1:0] J_LAST = IDX_W'(WORD_BITS - 1);

   slice_t               slice;
   logic [IDX_W-1:0]     j_q, j_d;
   logic [WORD_BITS-1:0] shreg_q, shreg_d;
   logic                 err_acc_q, err_acc_d;
   logic [WORD_BITS-1:0] ham_q, ham_d;
   logic                 word_valid_q, word_valid_d;
   logic                 sym_err_q, sym_err_d;

   fsk_bit_slicer u_slicer (
      .FSK_clk     (FSK_clk),
      .reset_n     (reset_n),
      .fsk         (fsk),
      .slice_o     (slice),
      .bit_out_o   (bit_out),
      .bit_valid_o (bit_valid)
   );

   always_comb begin
      j_d          = j_q;
      shreg_d      = shreg_q;
      err_acc_d    = err_acc_q;
      ham_d        = ham_q;
      word_valid_d = 1'b0;
      sym_err_d    = sym_err_q;

      if (slice.strobe) begin
         shreg_d[j_q] = slice.bit_val;
         if (j_q == J_LAST) begin
            // The last bit bypasses shreg so the word is published on its own decision edge.
            ham_d        = {slice.bit_val, shreg_q[WORD_BITS-2:0]};
            word_valid_d = 1'b1;
            sym_err_d    = err_acc_q | slice.err;
            j_d          = '0;
            err_acc_d    = 1'b0;
         end else begin
            j_d          = j_q + 1'b1;
            err_acc_d    = err_acc_q | slice.err;
         end
      end
   end

   always_ff @(posedge FSK_clk or negedge reset_n) begin
      if (!reset_n) begin
         j_q          <= '0;
         shreg_q      <= '0;
         err_acc_q    <= 1'b0;
         ham_q        <= '0;
         word_valid_q <= 1'b0;
         sym_err_q    <= 1'b0;
      end else begin
         j_q          <= j_d;
         shreg_q      <= shreg_d;
         err_acc_q    <= err_acc_d;
         ham_q        <= ham_d;
         word_valid_q <= word_valid_d;
         sym_err_q    <= sym_err_d;
      end
   end

   assign Hamcode_out = ham_q;
   assign word_valid  = word_valid_q;
   assign sym_err     = sym_err_q;

endmodule
